// File: rtl/armaria_pkg.sv
// Shared definitions for the banked register file: control opcodes, privilege
// modes and the interrupt-latch state encoding.
package armaria_pkg;

    localparam logic [2:0] CTL_NOP   = 3'd0;
    localparam logic [2:0] CTL_WRITE = 3'd1;
    localparam logic [2:0] CTL_SRST  = 3'd2;
    localparam logic [2:0] CTL_MEMIN = 3'd3;
    localparam logic [2:0] CTL_TRAP  = 3'd4;
    localparam logic [2:0] CTL_ERET  = 3'd5;

    localparam logic MODE_USER = 1'b0;
    localparam logic MODE_PRIV = 1'b1;

    typedef enum logic {
        IrqIdle,
        IrqPend
    } irq_state_e;

endpackage

// File: rtl/irq_latch.sv
// Interrupt request latch: holds a user-mode request until an enabled cycle can
// take it, and pulses the acknowledge for the cycle in which entry happens.
module irq_latch
    import armaria_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       irq_req_i,
    input  logic       mode_i,
    input  logic [2:0] ctl_i,
    output logic       ack_o
);

    irq_state_e state_q, state_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IrqIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ack_o   = 1'b0;
        case (state_q)
            // Requests are captured even while disabled so a pulse is not lost.
            IrqIdle: begin
                if (irq_req_i && (mode_i == MODE_USER)) begin
                    state_d = IrqPend;
                end
            end
            // Stays pending across a trap; taken once back in user mode.
            IrqPend: begin
                if (en_i && (mode_i == MODE_USER) &&
                    (ctl_i != CTL_TRAP) && (ctl_i != CTL_ERET)) begin
                    ack_o   = 1'b1;
                    state_d = IrqIdle;
                end
            end
            default: state_d = IrqIdle;
        endcase
    end

endmodule

// File: rtl/banked_reg_file.sv
// General register file with mode-banked SP/LR, PC ownership, privilege mode
// and exception entry/return sequencing.
module banked_reg_file
    import armaria_pkg::*;
#(
    parameter int unsigned       WIDTH      = 32,
    parameter int unsigned       NREGS      = 16,
    parameter int unsigned       LR_IDX     = 13,
    parameter int unsigned       SP_IDX     = 14,
    parameter int unsigned       PC_IDX     = 15,
    parameter logic [WIDTH-1:0]  PC_RESET   = WIDTH'(1),
    parameter logic [WIDTH-1:0]  SP_RESET   = '1,
    parameter logic [WIDTH-1:0]  DATA_START = WIDTH'(32'h8192),
    parameter bit                BYPASS     = 1'b1,
    localparam int unsigned      AW         = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [2:0]       control,
    input  logic [AW-1:0]    RegD,
    input  logic [AW-1:0]    RegA,
    input  logic [AW-1:0]    RegB,
    input  logic [WIDTH-1:0] Result,
    input  logic [WIDTH-1:0] MemIn,
    input  logic [WIDTH-1:0] PCin,
    input  logic [WIDTH-1:0] SPin,
    input  logic [WIDTH-1:0] vector,
    input  logic             irq_req,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] MemOut,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] SP,
    output logic [WIDTH-1:0] LR,
    output logic             mode,
    output logic             irq_ack
);

    localparam logic [AW-1:0] LrI = AW'(LR_IDX);
    localparam logic [AW-1:0] SpI = AW'(SP_IDX);
    localparam logic [AW-1:0] PcI = AW'(PC_IDX);

    logic [WIDTH-1:0] bank_q [NREGS];
    logic [WIDTH-1:0] bank_d [NREGS];
    logic [WIDTH-1:0] sp_q [2];
    logic [WIDTH-1:0] sp_d [2];
    logic [WIDTH-1:0] lr_q [2];
    logic [WIDTH-1:0] lr_d [2];
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             mode_q, mode_d;
    logic             smode_q, smode_d;

    logic [WIDTH-1:0] wr_data;
    logic             is_write;
    logic             fwd_en;
    logic             entry;
    logic [AW-1:0]    rd_sel;
    logic [WIDTH-1:0] rd_data [3];

    irq_latch u_irq_latch (
        .clk_i     (clock),
        .rst_ni    (reset),
        .en_i      (enable),
        .irq_req_i (irq_req),
        .mode_i    (mode_q),
        .ctl_i     (control),
        .ack_o     (irq_ack)
    );

    assign is_write = (control == CTL_WRITE) || (control == CTL_MEMIN);
    assign wr_data  = (control == CTL_MEMIN) ? MemIn : Result;
    assign fwd_en   = BYPASS && enable && is_write;
    assign entry    = (control == CTL_TRAP) || irq_ack;

    // Port 0 = A, 1 = B, 2 = store data (indexed by RegD).
    always_comb begin
        rd_sel = '0;
        for (int p = 0; p < 3; p++) begin
            rd_sel = (p == 0) ? RegA : (p == 1) ? RegB : RegD;
            if (rd_sel == SpI) begin
                rd_data[p] = sp_q[mode_q];
            end else if (rd_sel == LrI) begin
                rd_data[p] = lr_q[mode_q];
            end else if (rd_sel == PcI) begin
                rd_data[p] = pc_q;
            end else if (fwd_en && (rd_sel == RegD)) begin
                rd_data[p] = wr_data;
            end else begin
                rd_data[p] = bank_q[rd_sel];
            end
        end
    end

    assign A      = rd_data[0];
    assign B      = rd_data[1];
    assign MemOut = rd_data[2];
    assign PC     = pc_q;
    assign SP     = sp_q[mode_q];
    assign LR     = lr_q[mode_q];
    assign mode   = mode_q;

    always_comb begin
        bank_d  = bank_q;
        sp_d    = sp_q;
        lr_d    = lr_q;
        pc_d    = PCin;
        mode_d  = mode_q;
        smode_d = smode_q;
        if (entry) begin
            // SPs hold on entry; only the privileged LR captures the return PC.
            lr_d[MODE_PRIV] = pc_q;
            smode_d         = mode_q;
            mode_d          = MODE_PRIV;
            pc_d            = vector;
        end else begin
            sp_d[mode_q] = SPin;
            if (is_write) begin
                if (RegD == LrI) begin
                    lr_d[mode_q] = wr_data;
                end else if ((RegD != PcI) && (RegD != SpI)) begin
                    bank_d[RegD] = wr_data;
                end
            end else if (control == CTL_SRST) begin
                sp_d[mode_q] = SP_RESET;
                bank_d[0]    = DATA_START;
            end else if ((control == CTL_ERET) && (mode_q == MODE_PRIV)) begin
                pc_d   = lr_q[mode_q];
                mode_d = smode_q;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                bank_q[i] <= '0;
            end
            bank_q[0] <= DATA_START;
            sp_q[0]   <= SP_RESET;
            sp_q[1]   <= SP_RESET;
            lr_q[0]   <= '0;
            lr_q[1]   <= '0;
            pc_q      <= PC_RESET;
            mode_q    <= MODE_USER;
            smode_q   <= MODE_USER;
        end else if (enable) begin
            bank_q  <= bank_d;
            sp_q    <= sp_d;
            lr_q    <= lr_d;
            pc_q    <= pc_d;
            mode_q  <= mode_d;
            smode_q <= smode_d;
        end
    end

endmodule
